// File: rtl/load_scoreboard.sv
// Load scoreboard: records registers with outstanding long-latency loads at issue,
// retires them at writeback, and stalls RD on operands the forward mux cannot supply.
module load_scoreboard #(
  parameter int NUM_REGS        = 32,
  parameter int REG_W           = 5,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs,
  input  logic             rs_used,
  input  logic [REG_W-1:0] rt,
  input  logic             rt_used,
  input  logic             issue_valid,
  input  logic             issue_is_load,
  input  logic [REG_W-1:0] issue_dest,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_reg,
  output logic             stall,
  output logic             issue_accept,
  output logic [CNT_W-1:0] outstanding,
  output logic             full,
  output logic             wb_error
);

  localparam logic [REG_W-1:0] ZERO_REG = {REG_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_REGS-1:0] pend_r;
  logic [NUM_REGS-1:0] pend_nxt_s;
  logic [NUM_REGS-1:0] clr_s;
  logic [NUM_REGS-1:0] eff_s;
  logic [CNT_W-1:0]    outstanding_r;
  logic [CNT_W-1:0]    outstanding_nxt_s;
  logic                wb_error_r;
  logic                wb_error_nxt_s;
  logic                full_s;
  logic                rs_haz_s;
  logic                rt_haz_s;
  logic                waw_s;
  logic                cap_s;
  logic                stall_s;
  logic                set_s;
  logic                hit_s;

  // One-hot decode of the returning load's destination.
  always_comb begin
    clr_s = {NUM_REGS{1'b0}};
    if (wb_valid) begin
      clr_s[wb_reg] = 1'b1;
    end else begin
      clr_s = {NUM_REGS{1'b0}};
    end
  end

  // Hazard detection; a same-cycle writeback is satisfied by the WB forward path.
  always_comb begin
    eff_s    = pend_r & ~clr_s;
    full_s   = (outstanding_r == CNT_MAX);
    rs_haz_s = rs_used && (rs != ZERO_REG) && eff_s[rs];
    rt_haz_s = rt_used && (rt != ZERO_REG) && eff_s[rt];
    waw_s    = issue_is_load && (issue_dest != ZERO_REG) && eff_s[issue_dest];
    cap_s    = issue_is_load && full_s && !wb_valid;
    stall_s  = rs_haz_s || rt_haz_s || waw_s || cap_s;
    set_s    = issue_valid && !stall_s && issue_is_load && (issue_dest != ZERO_REG);
    hit_s    = wb_valid && (wb_reg != ZERO_REG) && pend_r[wb_reg];
  end

  // Next-state: clear is applied first so a same-register set wins.
  always_comb begin
    pend_nxt_s = pend_r & ~clr_s;
    if (set_s) begin
      pend_nxt_s[issue_dest] = 1'b1;
    end else begin
      pend_nxt_s[0] = 1'b0;
    end

    outstanding_nxt_s = outstanding_r;
    case ({set_s, hit_s})
      2'b10: begin
        if (outstanding_r != CNT_MAX) begin
          outstanding_nxt_s = outstanding_r + CNT_ONE;
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      2'b01: begin
        if (outstanding_r != CNT_ZERO) begin
          outstanding_nxt_s = outstanding_r - CNT_ONE;
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      default: outstanding_nxt_s = outstanding_r;
    endcase

    wb_error_nxt_s = wb_error_r | (wb_valid && !hit_s);
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r        <= {NUM_REGS{1'b0}};
      outstanding_r <= CNT_ZERO;
      wb_error_r    <= 1'b0;
    end else begin
      pend_r        <= pend_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      wb_error_r    <= wb_error_nxt_s;
    end
  end

  assign stall        = stall_s;
  assign issue_accept = issue_valid && !stall_s;
  assign outstanding  = outstanding_r;
  assign full         = full_s;
  assign wb_error     = wb_error_r;

endmodule
